rom_access_arbiter: RTL and testbench
=====================================

// Module: rom_access_arbiter
// PURPOSE
//  Shares one synchronous-read ROM between two requesters: port 0 (instruction fetch) and port 1 (constant/data load).
//  Each port has a valid/ready request channel and a valid/ready response channel.
//  Only one ROM read is outstanding at a time. Ties are resolved round-robin.
//  Sits between the MiniMicro core front end and the ROM instance.
//
// PARAMETERS
//  DATA_LENGTH  32  ROM word width (bits)
//  MEM_DEPTH    32  ROM words; ADDR_W = $clog2(MEM_DEPTH)
//  ROM_LAT      1   edges from ROM address sample to valid return_data (0 = combinational ROM)
//
// PORTS
//  clk           in   1            single clock, all state updates on posedge
//  rst_n         in   1            synchronous, active-low reset
//  req0_valid    in   1            port 0 request valid
//  req0_addr     in   ADDR_W       port 0 word address
//  req0_ready    out  1            port 0 request accepted this cycle
//  rsp0_valid    out  1            port 0 response data valid
//  rsp0_data     out  DATA_LENGTH  port 0 response data
//  rsp0_ready    in   1            port 0 consumer accepts response
//  req1_*/rsp1_* same as port 0, for port 1
//  rom_address   out  ADDR_W       registered address to ROM
//  rom_data      in   DATA_LENGTH  ROM return_data
//
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, addr_q=0, data_q=0, owner=0, last_grant=1, cnt=0.
//   All req*_ready=0, all rsp*_valid=0, rom_address=0, rsp*_data=0.
//  FSM states: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE
//   - reqX_ready is combinational: (state==IDLE) & reqX_valid & grant==X.
//   - Grant: if only one port is valid, that port wins.
//     If both are valid, the port != last_grant wins.
//   - On the accept edge E0: addr_q<=addr of winner, owner<=winner, last_grant<=winner, cnt<=ROM_LAT, state->WAIT.
//   - With no request valid, the block stays in IDLE; addr_q is held.
//  WAIT
//   - rom_address=addr_q (stable for the entire WAIT).
//   - Each edge: if cnt!=0, cnt<=cnt-1.
//   - On the edge where cnt==0: data_q<=rom_data, state->RESP.
//   - WAIT lasts ROM_LAT+1 cycles. ROM_LAT=1: accept at E0, rsp valid after E2.
//  RESP
//   - rsp<owner>_valid=1 and rsp<owner>_data=data_q; the other port's rsp_valid=0.
//   - Held until rsp<owner>_ready=1; on that edge state->IDLE.
//   - No new request is accepted in the same cycle; peak throughput is 1 read per ROM_LAT+3 cycles.
//  Boundary conditions
//   - rsp_ready asserted early (before RESP) is ignored.
//   - Back-pressure (rsp_ready=0) stalls indefinitely. Other requests wait and are not dropped.
//   - A request with valid deasserted before ready is not granted (no latching of unaccepted requests).
//   - req addr >= MEM_DEPTH cannot occur (ADDR_W sized). If MEM_DEPTH is not a power of 2, the address is passed through unchanged; ROM behaviour is defined by the ROM.
//   - rsp*_data outside RESP drives data_q (don't-care for consumers; stable).
//   - Reset mid-WAIT/RESP: the in-flight response is discarded, no rsp_valid is emitted, and all state returns to reset values on that edge.
//   - Starvation-free: under continuous requests from both ports, grants alternate 0,1,0,1...
//
// STRUCTURE
//  rom_arb_pkg: typedef enum logic [1:0] {IDLE, WAIT, RESP} rom_arb_state_t; also the grant index type.
//  Sub-module rom_rr_arbiter: 2-way round-robin pick.
//   - Inputs: valid[1:0], last_grant. Outputs: grant, any_valid. Purely combinational.
//   - The last_grant register stays in the top.
//  Top holds the FSM, addr_q, data_q, cnt ($clog2(ROM_LAT+1) bits, min 1), owner.
//
// TESTING (bench uses ROM preloaded mem[i]=i*3+7, ROM_LAT=1, rsp_ready=1 unless stated)
//  1 Single port-0 read addr 5 -> req0_ready 1 cycle; rsp0_valid 2 edges later, data 22; rsp1_valid stays 0.
//  2 Both valid from reset, addr0=2, addr1=9 -> port 0 served first (13), then port 1 (34); then alternate over 8 back-to-back reads.
//  3 Port 1 rsp1_ready=0 for 5 cycles -> rsp1_valid/data 34 held stable for all 5; req0 stalled (req0_ready=0) until accept.
//  4 rst_n=0 during WAIT -> next cycle IDLE, no rsp*_valid pulse, rom_address=0; fresh read addr 31 returns 100.
//  5 Sweep addr 0..MEM_DEPTH-1 on port 0 -> every rsp0_data == addr*3+7; rom_address stable through every WAIT.
//  6 ROM_LAT=0 and ROM_LAT=3 builds -> accept-to-rsp_valid exactly ROM_LAT+1 edges; data is correct.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM access arbiter.
// Holds the FSM encoding, the grant index type and the sizing helper.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } rom_arb_state_t;

   typedef logic grant_idx_t;

   // The latency counter must hold ROM_LAT and still be at least one bit wide.
   function automatic int cnt_width(input int lat);
      return (lat > 0) ? $clog2(lat + 1) : 1;
   endfunction

endpackage

// File: rtl/rom_rr_arbiter.sv
// Two-way round-robin pick, purely combinational.
// The caller owns the last_grant register and updates it on accept.
module rom_rr_arbiter
   import rom_arb_pkg::*;
(
   input  logic [1:0] valid,
   input  grant_idx_t last_grant,
   output grant_idx_t grant,
   output logic       any_valid
);

   always_comb begin
      any_valid = |valid;
      grant     = ~last_grant;
      if (valid == 2'b11) begin
         grant = ~last_grant;
      end else if (valid[1]) begin
         grant = 1'b1;
      end else if (valid[0]) begin
         grant = 1'b0;
      end
   end

endmodule

// File: rtl/rom_access_arbiter.sv
// Shares one synchronous-read ROM between an instruction-fetch port (0) and a
// data-load port (1). One read in flight at a time, ties resolved round-robin.
module rom_access_arbiter
   import rom_arb_pkg::*;
#(
   parameter  int DATA_LENGTH = 32,
   parameter  int MEM_DEPTH   = 32,
   parameter  int ROM_LAT     = 1,
   localparam int ADDR_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_valid,
   input  logic [ADDR_W-1:0]      req0_addr,
   output logic                   req0_ready,
   output logic                   rsp0_valid,
   output logic [DATA_LENGTH-1:0] rsp0_data,
   input  logic                   rsp0_ready,
   input  logic                   req1_valid,
   input  logic [ADDR_W-1:0]      req1_addr,
   output logic                   req1_ready,
   output logic                   rsp1_valid,
   output logic [DATA_LENGTH-1:0] rsp1_data,
   input  logic                   rsp1_ready,
   output logic [ADDR_W-1:0]      rom_address,
   input  logic [DATA_LENGTH-1:0] rom_data,
   output rom_arb_state_t         state_dbg
);

   // Handshake rule: a transfer happens on a rising edge where valid and ready
   // are both high. Requesters hold valid and addr stable until ready; an
   // unaccepted request that drops valid is forgotten. Responses hold valid
   // and data stable until the owner's rsp_ready.

   localparam int                CNT_W    = cnt_width(ROM_LAT);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(ROM_LAT);

   rom_arb_state_t         state;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_LENGTH-1:0] data_q;
   grant_idx_t             owner;
   grant_idx_t             last_grant;
   logic [CNT_W-1:0]       cnt;

   grant_idx_t             grant;
   logic                   any_valid;
   logic                   owner_ready;

   rom_rr_arbiter u_rr (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant),
      .any_valid  (any_valid)
   );

   assign req0_ready  = (state == IDLE) && req0_valid && (grant == 1'b0);
   assign req1_ready  = (state == IDLE) && req1_valid && (grant == 1'b1);

   assign rsp0_valid  = (state == RESP) && (owner == 1'b0);
   assign rsp1_valid  = (state == RESP) && (owner == 1'b1);
   assign rsp0_data   = data_q;
   assign rsp1_data   = data_q;

   assign rom_address = addr_q;
   assign state_dbg   = state;
   assign owner_ready = owner ? rsp1_ready : rsp0_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr_q     <= '0;
         data_q     <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  addr_q     <= grant ? req1_addr : req0_addr;
                  owner      <= grant;
                  last_grant <= grant;
                  cnt        <= CNT_INIT;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               // addr_q stays put here, so the ROM sees a stable address
               // for the whole countdown.
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  data_q <= rom_data;
                  state  <= RESP;
               end
            end
            RESP: begin
               if (owner_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   rsp_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp0_valid && rsp1_valid));

   req_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(req0_ready && req1_ready));

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Bench for rom_access_arbiter: three builds (ROM_LAT 1, 0, 3) each with a
// ROM model holding mem[i] = i*3+7, checked against a high-level model.
module tb_rom_access_arbiter;
   import rom_arb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NI = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic           req_valid   [NI][2];
   logic [AW-1:0]  req_addr    [NI][2];
   logic           req_ready   [NI][2];
   logic           rsp_valid   [NI][2];
   logic [DW-1:0]  rsp_data    [NI][2];
   logic           rsp_ready   [NI][2];
   logic [AW-1:0]  rom_address [NI];
   logic [DW-1:0]  rom_data    [NI];
   rom_arb_state_t state_dbg   [NI];

   logic [DW-1:0]  mem [32];
   logic [DW-1:0]  exp_q [$];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] model_word(input int a);
      return DW'(a * 3 + 7);
   endfunction

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      logic [DW-1:0] pipe [1:3];

      rom_access_arbiter #(.DATA_LENGTH(DW), .MEM_DEPTH(32), .ROM_LAT(LAT)) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .req0_valid  (req_valid[g][0]),
         .req0_addr   (req_addr[g][0]),
         .req0_ready  (req_ready[g][0]),
         .rsp0_valid  (rsp_valid[g][0]),
         .rsp0_data   (rsp_data[g][0]),
         .rsp0_ready  (rsp_ready[g][0]),
         .req1_valid  (req_valid[g][1]),
         .req1_addr   (req_addr[g][1]),
         .req1_ready  (req_ready[g][1]),
         .rsp1_valid  (rsp_valid[g][1]),
         .rsp1_data   (rsp_data[g][1]),
         .rsp1_ready  (rsp_ready[g][1]),
         .rom_address (rom_address[g]),
         .rom_data    (rom_data[g]),
         .state_dbg   (state_dbg[g])
      );

      if (LAT == 0) begin : g_comb
         assign rom_data[g] = mem[rom_address[g]];
      end else begin : g_sync
         always @(posedge clk) begin
            pipe[1] <= mem[rom_address[g]];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
         end
         assign rom_data[g] = pipe[LAT];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one read and reports latency (edges after the accept edge),
   // returned data and protocol observations. Assumes rsp_ready=1.
   task automatic do_read(input int k, input int p, input logic [AW-1:0] a,
                          output int lat, output logic [DW-1:0] d,
                          output bit tmo, output bit other_seen, output bit addr_bad);
      int w;
      tmo = 0; other_seen = 0; addr_bad = 0; lat = 0; d = '0; w = 0;
      req_addr[k][p]  = a;
      req_valid[k][p] = 1'b1;
      #1;
      while (req_ready[k][p] !== 1'b1 && w < 20) begin
         tick();
         w++;
      end
      if (w >= 20) begin
         tmo = 1;
         req_valid[k][p] = 1'b0;
         return;
      end
      tick();
      req_valid[k][p] = 1'b0;
      while (rsp_valid[k][p] !== 1'b1 && lat < 20) begin
         if (rom_address[k] !== a) addr_bad = 1;
         if (rsp_valid[k][1-p] !== 1'b0) other_seen = 1;
         tick();
         lat++;
      end
      if (lat >= 20) tmo = 1;
      d = rsp_data[k][p];
      if (rsp_valid[k][1-p] !== 1'b0) other_seen = 1;
      tick();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      for (int k = 0; k < NI; k++) begin
         n_tests++;
         if (state_dbg[k] !== IDLE || rom_address[k] !== '0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: state=%0d addr=%0h, want state=0 addr=0", k, state_dbg[k], rom_address[k]);
         end
         for (int p = 0; p < 2; p++) begin
            n_tests++;
            if (rsp_valid[k][p] !== 1'b0 || req_ready[k][p] !== 1'b0 || rsp_data[k][p] !== '0) begin
               n_fail++;
               $display("FAIL reset_outputs[%0d][%0d]: rsp_valid=%b req_ready=%b data=%0h, want 0 0 0",
                        k, p, rsp_valid[k][p], req_ready[k][p], rsp_data[k][p]);
            end
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      int lat;
      bit seen1;
      lat = 0; seen1 = 0;
      req_addr[0][0]  = 5'd5;
      req_valid[0][0] = 1'b1;
      #1;
      n_tests++;
      if (req_ready[0][0] !== 1'b1) begin
         n_fail++;
         $display("FAIL single_ready: got %b want 1", req_ready[0][0]);
      end
      tick();
      n_tests++;
      if (req_ready[0][0] !== 1'b0 || state_dbg[0] !== WAIT) begin
         n_fail++;
         $display("FAIL single_ready_pulse: ready=%b state=%0d, want ready=0 state=WAIT", req_ready[0][0], state_dbg[0]);
      end
      req_valid[0][0] = 1'b0;
      while (rsp_valid[0][0] !== 1'b1 && lat < 10) begin
         if (rsp_valid[0][1] !== 1'b0) seen1 = 1;
         tick();
         lat++;
      end
      n_tests++;
      if (lat != 2) begin
         n_fail++;
         $display("FAIL single_latency: got %0d want 2", lat);
      end
      n_tests++;
      if (rsp_data[0][0] !== model_word(5)) begin
         n_fail++;
         $display("FAIL single_data: got %0d want %0d", rsp_data[0][0], model_word(5));
      end
      n_tests++;
      if (seen1 || rsp_valid[0][1] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_other_port: rsp1_valid seen=%b now=%b want 0", seen1, rsp_valid[0][1]);
      end
      tick();
      n_tests++;
      if (rsp_valid[0][0] !== 1'b0) begin
         n_fail++;
         $display("FAIL single_release: rsp0_valid=%b want 0", rsp_valid[0][0]);
      end
   endtask

   task automatic test_round_robin();
      int model_last;
      int exp_port;
      int lat;
      int w;
      logic [AW-1:0] cur [2];
      logic [DW-1:0] exp_d;
      apply_reset();
      model_last = 1;
      cur[0] = 5'd2;
      cur[1] = 5'd9;
      for (int t = 0; t < 10; t++) begin
         req_addr[0][0]  = cur[0];
         req_addr[0][1]  = cur[1];
         req_valid[0][0] = 1'b1;
         req_valid[0][1] = 1'b1;
         #1;
         w = 0;
         while (req_ready[0][0] !== 1'b1 && req_ready[0][1] !== 1'b1 && w < 10) begin
            tick();
            w++;
         end
         exp_port = (model_last == 0) ? 1 : 0;
         n_tests++;
         if (req_ready[0][exp_port] !== 1'b1 || req_ready[0][1-exp_port] !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_grant t=%0d: ready0=%b ready1=%b, want port %0d", t, req_ready[0][0], req_ready[0][1], exp_port);
         end
         exp_q.push_back(model_word(int'(cur[exp_port])));
         model_last = exp_port;
         tick();
         cur[exp_port] = AW'($urandom_range(0, 31));
         req_addr[0][exp_port] = cur[exp_port];
         lat = 0;
         while (rsp_valid[0][0] !== 1'b1 && rsp_valid[0][1] !== 1'b1 && lat < 10) begin
            tick();
            lat++;
         end
         exp_d = exp_q.pop_front();
         n_tests++;
         if (rsp_valid[0][exp_port] !== 1'b1 || rsp_valid[0][1-exp_port] !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("FAIL rr_rsp t=%0d: rsp0=%b rsp1=%b lat=%0d, want port %0d lat 2", t, rsp_valid[0][0], rsp_valid[0][1], lat, exp_port);
         end
         n_tests++;
         if (rsp_data[0][exp_port] !== exp_d) begin
            n_fail++;
            $display("FAIL rr_data t=%0d: got %0d want %0d", t, rsp_data[0][exp_port], exp_d);
         end
         tick();
      end
      req_valid[0][0] = 1'b0;
      req_valid[0][1] = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      int w;
      int lat;
      rsp_ready[0][1] = 1'b0;
      req_addr[0][1]  = 5'd9;
      req_valid[0][1] = 1'b1;
      #1;
      w = 0;
      while (req_ready[0][1] !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      tick();
      req_valid[0][1] = 1'b0;
      w = 0;
      while (rsp_valid[0][1] !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      req_addr[0][0]  = 5'd0;
      req_valid[0][0] = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (rsp_valid[0][1] !== 1'b1 || rsp_data[0][1] !== model_word(9) ||
             req_ready[0][0] !== 1'b0 || rsp_valid[0][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold cyc=%0d: rsp1_valid=%b data=%0d req0_ready=%b rsp0_valid=%b, want 1 %0d 0 0",
                     i, rsp_valid[0][1], rsp_data[0][1], req_ready[0][0], rsp_valid[0][0], model_word(9));
         end
         tick();
      end
      rsp_ready[0][1] = 1'b1;
      tick();
      n_tests++;
      if (req_ready[0][0] !== 1'b1 || rsp_valid[0][1] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: req0_ready=%b rsp1_valid=%b, want 1 0", req_ready[0][0], rsp_valid[0][1]);
      end
      tick();
      req_valid[0][0] = 1'b0;
      lat = 0;
      while (rsp_valid[0][0] !== 1'b1 && lat < 10) begin
         tick();
         lat++;
      end
      n_tests++;
      if (rsp_data[0][0] !== model_word(0) || lat != 2) begin
         n_fail++;
         $display("FAIL bp_followup: data=%0d lat=%0d, want %0d lat 2", rsp_data[0][0], lat, model_word(0));
      end
      tick();
   endtask

   task automatic test_reset_mid_wait();
      int lat;
      logic [DW-1:0] d;
      bit tmo, other_seen, addr_bad, pulse;
      pulse = 0;
      req_addr[0][0]  = 5'd3;
      req_valid[0][0] = 1'b1;
      #1;
      tick();
      req_valid[0][0] = 1'b0;
      rst_n = 1'b0;
      tick();
      n_tests++;
      if (state_dbg[0] !== IDLE || rom_address[0] !== '0 || rsp_valid[0][0] !== 1'b0 || rsp_data[0][0] !== '0) begin
         n_fail++;
         $display("FAIL midreset_state: state=%0d addr=%0h rsp0_valid=%b data=%0h, want IDLE 0 0 0",
                  state_dbg[0], rom_address[0], rsp_valid[0][0], rsp_data[0][0]);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid[0][0] !== 1'b0 || rsp_valid[0][1] !== 1'b0) pulse = 1;
         tick();
      end
      n_tests++;
      if (pulse) begin
         n_fail++;
         $display("FAIL midreset_pulse: rsp_valid seen=1 want 0");
      end
      do_read(0, 0, 5'd31, lat, d, tmo, other_seen, addr_bad);
      n_tests++;
      if (tmo || d !== model_word(31) || lat != 2) begin
         n_fail++;
         $display("FAIL midreset_fresh: data=%0d lat=%0d tmo=%b, want %0d lat 2", d, lat, tmo, model_word(31));
      end
   endtask

   task automatic test_sweep();
      int lat;
      logic [DW-1:0] d;
      bit tmo, other_seen, addr_bad;
      for (int a = 0; a < 32; a++) begin
         do_read(0, 0, AW'(a), lat, d, tmo, other_seen, addr_bad);
         n_tests++;
         if (tmo || d !== model_word(a) || lat != 2) begin
            n_fail++;
            $display("FAIL sweep_data a=%0d: data=%0d lat=%0d tmo=%b, want %0d lat 2", a, d, lat, tmo, model_word(a));
         end
         n_tests++;
         if (addr_bad || other_seen) begin
            n_fail++;
            $display("FAIL sweep_addr a=%0d: addr_unstable=%b rsp1_seen=%b, want 0 0", a, addr_bad, other_seen);
         end
      end
   endtask

   task automatic test_latency_builds();
      int lat;
      int p;
      int a;
      logic [DW-1:0] d;
      bit tmo, other_seen, addr_bad;
      for (int k = 1; k < NI; k++) begin
         for (int t = 0; t < 8; t++) begin
            p = $urandom_range(0, 1);
            a = $urandom_range(0, 31);
            do_read(k, p, AW'(a), lat, d, tmo, other_seen, addr_bad);
            n_tests++;
            if (tmo || lat != lat_of(k) + 1 || d !== model_word(a) || addr_bad || other_seen) begin
               n_fail++;
               $display("FAIL latency_build lat=%0d port=%0d a=%0d: got lat %0d data %0d (tmo=%b ab=%b os=%b), want lat %0d data %0d",
                        lat_of(k), p, a, lat, d, tmo, addr_bad, other_seen, lat_of(k) + 1, model_word(a));
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = DW'(i) * 3 + 7;
      for (int k = 0; k < NI; k++) begin
         for (int p = 0; p < 2; p++) begin
            req_valid[k][p] = 1'b0;
            req_addr[k][p]  = '0;
            rsp_ready[k][p] = 1'b1;
         end
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_backpressure();
      test_reset_mid_wait();
      test_sweep();
      test_latency_builds();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
